// File: rtl/i3c_rx_word_pack_if.sv
// Byte-in / word-out handshake bundle for the I3C receive word packer.
interface i3c_rx_word_pack_if;
    logic        fb_ready;
    logic [7:0]  fb_data;
    logic        fb_ack;
    logic        fb_flush;
    logic        msg_end;
    logic        flush_req;
    logic        rd_valid;
    logic [31:0] rd_word;
    logic [2:0]  rd_bcnt;
    logic        rd_last;
    logic        rd_pop;
    logic [1:0]  word_cnt;
    logic        uflow;
    logic        clear_uflow;

    modport slave (
        input  fb_ready, fb_data, msg_end, flush_req, rd_pop, clear_uflow,
        output fb_ack, fb_flush, rd_valid, rd_word, rd_bcnt, rd_last, word_cnt, uflow
    );

    modport master (
        output fb_ready, fb_data, msg_end, flush_req, rd_pop, clear_uflow,
        input  fb_ack, fb_flush, rd_valid, rd_word, rd_bcnt, rd_last, word_cnt, uflow
    );
endinterface

// File: rtl/i3c_rx_word_pack.sv
// Packs from-bus bytes little-endian into 32-bit words queued in a 2-entry FIFO.
// Word visible one edge after its closing event; fb_ack drops while a full word waits on a full FIFO or during flush.
module i3c_rx_word_pack #(
    parameter int TO_CNT_W = 8,
    parameter int TO_LIMIT = 200
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    i3c_rx_word_pack_if.slave    bus
);
    localparam bit                  LP_TO_EN  = (TO_LIMIT != 0);
    localparam logic [TO_CNT_W-1:0] LP_TO_HIT = TO_CNT_W'((TO_LIMIT > 0) ? TO_LIMIT - 1 : 0);

    logic [31:0]         r_acc;
    logic [2:0]          r_bcnt;
    logic                r_close_pend;
    logic                r_close_last;
    logic [TO_CNT_W-1:0] r_to_cnt;
    logic                r_fb_flush;
    logic [1:0]          r_wptr;
    logic [1:0]          r_rptr;
    logic [31:0]         r_mem_word [2];
    logic [2:0]          r_mem_bcnt [2];
    logic                r_mem_last [2];
    logic                r_uflow;

    logic [1:0] w_word_cnt;
    logic       w_full;
    logic       w_rd_valid;
    logic       w_blk;
    logic       w_commit;
    logic       w_accept;
    logic [1:0] w_lane;
    logic       w_held;
    logic       w_me_set;
    logic       w_to_hit;
    logic       w_pop;

    assign w_word_cnt = r_wptr - r_rptr;
    assign w_full     = (w_word_cnt == 2'd2);
    assign w_rd_valid = (r_wptr != r_rptr);
    assign w_blk      = bus.flush_req | r_fb_flush;
    // Commit sees this cycle's occupancy only, so a same-cycle pop cannot unblock it.
    assign w_commit   = ((r_bcnt == 3'd4) | r_close_pend) & ~w_full;
    assign w_accept   = bus.fb_ready & ~w_blk & (((r_bcnt < 3'd4) & ~r_close_pend) | w_commit);
    assign w_lane     = w_commit ? 2'd0 : r_bcnt[1:0];
    assign w_held     = (r_bcnt != 3'd0);
    assign w_me_set   = bus.msg_end & ((w_held & ~w_commit) | w_accept);
    assign w_to_hit   = LP_TO_EN & (r_to_cnt == LP_TO_HIT) & w_held & (r_bcnt != 3'd4)
                        & ~r_close_pend & ~w_accept;
    assign w_pop      = bus.rd_pop & w_rd_valid;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_acc        <= '0;
            r_bcnt       <= '0;
            r_close_pend <= 1'b0;
            r_close_last <= 1'b0;
            r_to_cnt     <= '0;
        end else if (bus.flush_req) begin
            r_acc        <= '0;
            r_bcnt       <= '0;
            r_close_pend <= 1'b0;
            r_close_last <= 1'b0;
            r_to_cnt     <= '0;
        end else begin
            if (w_commit) begin
                r_acc  <= w_accept ? {24'h0, bus.fb_data} : 32'h0;
                r_bcnt <= w_accept ? 3'd1 : 3'd0;
            end else if (w_accept) begin
                r_acc[{w_lane, 3'b000} +: 8] <= bus.fb_data;
                r_bcnt                       <= r_bcnt + 3'd1;
            end

            // msg_end outranks timeout so the word is tagged as a message end.
            if (w_me_set) begin
                r_close_pend <= 1'b1;
                r_close_last <= 1'b1;
            end else if (w_to_hit) begin
                r_close_pend <= 1'b1;
                r_close_last <= 1'b0;
            end else if (w_commit) begin
                r_close_pend <= 1'b0;
            end

            if (w_accept | w_commit | ~w_held) begin
                r_to_cnt <= '0;
            end else if (~r_close_pend & (r_bcnt != 3'd4)) begin
                r_to_cnt <= r_to_cnt + TO_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < 2; i++) begin
                r_mem_word[i] <= '0;
                r_mem_bcnt[i] <= '0;
                r_mem_last[i] <= 1'b0;
            end
        end else if (bus.flush_req) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_commit) begin
                r_mem_word[r_wptr[0]] <= r_acc;
                r_mem_bcnt[r_wptr[0]] <= r_bcnt;
                r_mem_last[r_wptr[0]] <= r_close_last & r_close_pend;
                r_wptr                <= r_wptr + 2'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 2'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_fb_flush <= 1'b0;
            r_uflow    <= 1'b0;
        end else begin
            r_fb_flush <= bus.flush_req;
            if (bus.clear_uflow) begin
                r_uflow <= 1'b0;
            end else if (bus.rd_pop & ~w_rd_valid) begin
                r_uflow <= 1'b1;
            end
        end
    end

    assign bus.fb_ack   = w_accept;
    assign bus.fb_flush = r_fb_flush;
    assign bus.rd_valid = w_rd_valid;
    assign bus.rd_word  = r_mem_word[r_rptr[0]];
    assign bus.rd_bcnt  = r_mem_bcnt[r_rptr[0]];
    assign bus.rd_last  = r_mem_last[r_rptr[0]];
    assign bus.word_cnt = w_word_cnt;
    assign bus.uflow    = r_uflow;
endmodule
